// File: rtl/data_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_hazard_unit
// Description : OF-stage data hazard detector for the 5-stage SimpleRISC pipe.
//               Keeps a shadow pipeline of destination tags (EX/MA/RW) and
//               produces the OF stall, per-operand forwarding selects, the
//               EX bubble decision and a saturating stall-cycle counter.
//               Macro HAZARD_FWD_EN: defined -> forwarding, load-use stalls
//               only; undefined -> full interlock, selects tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module data_hazard_unit #(
    parameter int RA_REG          = 15,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      of_ir,
    input  logic             of_valid,
    input  logic             freeze,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [4:0] c_OP_ALU_MAX = 5'b01100;
    localparam logic [4:0] c_OP_CMP     = 5'b00101;
    localparam logic [4:0] c_OP_NOT     = 5'b01000;
    localparam logic [4:0] c_OP_MOV     = 5'b01001;
    localparam logic [4:0] c_OP_LD      = 5'b01110;
    localparam logic [4:0] c_OP_ST      = 5'b01111;
    localparam logic [4:0] c_OP_CALL    = 5'b10011;
    localparam logic [4:0] c_OP_RET     = 5'b10100;
    localparam logic [3:0] c_RA         = 4'(RA_REG);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic       is_ld;
        logic [3:0] dest;
    } slot_t;

    localparam slot_t c_BUBBLE = '0;

    slot_t      r_ex, r_ma, r_rw;
    slot_t      w_dec;
    logic       w_has_src1, w_has_src2;
    logic [3:0] w_src1, w_src2;
    logic [4:0] w_op;
    logic       w_is_alu;
    logic       w_m1_ex, w_m1_ma, w_m1_rw;
    logic       w_m2_ex, w_m2_ma, w_m2_rw;
    logic       w_raw_stall;

    // Immediate/offset low bits never affect hazards; the RW load flag is
    // carried only so the slot format stays uniform.
    logic w_unused_bits;
    assign w_unused_bits = ^{of_ir[13:0], r_rw.is_ld};

    // Decode the OF instruction into its destination tag and source usage.
    always_comb begin
        w_op         = of_ir[31:27];
        w_is_alu     = (w_op <= c_OP_ALU_MAX);
        w_dec.valid  = 1'b1;
        w_dec.writes = (w_is_alu && (w_op != c_OP_CMP)) || (w_op == c_OP_LD) || (w_op == c_OP_CALL);
        w_dec.is_ld  = (w_op == c_OP_LD);
        w_dec.dest   = (w_op == c_OP_CALL) ? c_RA : of_ir[25:22];
        w_has_src1   = (w_is_alu && (w_op != c_OP_NOT) && (w_op != c_OP_MOV))
                     || (w_op == c_OP_LD) || (w_op == c_OP_ST) || (w_op == c_OP_RET);
        w_src1       = (w_op == c_OP_RET) ? c_RA : of_ir[21:18];
        w_has_src2   = (w_op == c_OP_ST) || (w_is_alu && !of_ir[26]);
        w_src2       = (w_op == c_OP_ST) ? of_ir[25:22] : of_ir[17:14];
    end

    // Compare each used source against every producing shadow slot.
    always_comb begin
        w_m1_ex = w_has_src1 && r_ex.valid && r_ex.writes && (w_src1 == r_ex.dest);
        w_m1_ma = w_has_src1 && r_ma.valid && r_ma.writes && (w_src1 == r_ma.dest);
        w_m1_rw = w_has_src1 && r_rw.valid && r_rw.writes && (w_src1 == r_rw.dest);
        w_m2_ex = w_has_src2 && r_ex.valid && r_ex.writes && (w_src2 == r_ex.dest);
        w_m2_ma = w_has_src2 && r_ma.valid && r_ma.writes && (w_src2 == r_ma.dest);
        w_m2_rw = w_has_src2 && r_rw.valid && r_rw.writes && (w_src2 == r_rw.dest);
    end

`ifdef HAZARD_FWD_EN
    // A load still in MA is unusable when loads need the full two-cycle latency.
    localparam bit c_LD_IN_MA_BLOCKS = (LOAD_USE_STALLS == 2);

    // Youngest matching producer wins; a match on a not-yet-ready load yields
    // 0 because the instruction is stalled that cycle anyway.
    function automatic logic [1:0] pick_sel(input logic m_ex, input logic m_ma,
                                            input logic m_rw, input logic ex_ld,
                                            input logic ma_ld);
        if (m_ex)
            pick_sel = ex_ld ? 2'd0 : 2'd1;
        else if (m_ma)
            pick_sel = (ma_ld && c_LD_IN_MA_BLOCKS) ? 2'd0 : 2'd2;
        else if (m_rw)
            pick_sel = 2'd3;
        else
            pick_sel = 2'd0;
    endfunction

    // Only load-use dependences stall; everything else is forwarded.
    always_comb begin
        w_raw_stall = of_valid && (
                      ((w_m1_ex || w_m2_ex) && r_ex.is_ld)
                   || ((w_m1_ma || w_m2_ma) && r_ma.is_ld && c_LD_IN_MA_BLOCKS));
        fwd_a_sel   = of_valid ? pick_sel(w_m1_ex, w_m1_ma, w_m1_rw, r_ex.is_ld, r_ma.is_ld) : 2'd0;
        fwd_b_sel   = of_valid ? pick_sel(w_m2_ex, w_m2_ma, w_m2_rw, r_ex.is_ld, r_ma.is_ld) : 2'd0;
    end
`else
    // Full interlock: any in-flight producer of a source holds OF.
    always_comb begin
        w_raw_stall = of_valid && (w_m1_ex || w_m1_ma || w_m1_rw
                                || w_m2_ex || w_m2_ma || w_m2_rw);
        fwd_a_sel   = 2'd0;
        fwd_b_sel   = 2'd0;
    end
`endif

    assign stall = w_raw_stall & ~flush;

    // Advance the shadow pipeline and count stall cycles unless frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex        <= c_BUBBLE;
            r_ma        <= c_BUBBLE;
            r_rw        <= c_BUBBLE;
            stall_count <= '0;
        end else if (!freeze) begin
            r_rw <= r_ma;
            r_ma <= r_ex;
            r_ex <= (stall || flush || !of_valid) ? c_BUBBLE : w_dec;
            if (stall && (stall_count != c_CNT_MAX))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_hazard_unit
// Description : Directed self-checking bench for data_hazard_unit. Two
//               instances share stimulus: dut (LOAD_USE_STALLS=1, CNT_W=4)
//               and dut2 (LOAD_USE_STALLS=2, CNT_W=16). Expectations follow
//               HAZARD_FWD_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_hazard_unit;

`ifdef HAZARD_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    localparam logic [4:0] c_ADD = 5'b00000;
    localparam logic [4:0] c_SUB = 5'b00001;
    localparam logic [31:0] c_CALL = {5'b10011, 27'd0};
    localparam logic [31:0] c_RET  = {5'b10100, 27'd0};

    logic        clk = 1'b0;
    logic        reset, of_valid, freeze, flush;
    logic [31:0] of_ir;
    logic        stall, stall2;
    logic [1:0]  a_sel, b_sel, a_sel2, b_sel2;
    logic [3:0]  cnt;
    logic [15:0] cnt2;
    logic [4:0]  o1, o2, e;
    int          n_vec = 0;
    int          n_miss = 0;

    assign o1 = {stall, a_sel, b_sel};
    assign o2 = {stall2, a_sel2, b_sel2};

    data_hazard_unit #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .of_ir(of_ir), .of_valid(of_valid),
        .freeze(freeze), .flush(flush), .stall(stall),
        .fwd_a_sel(a_sel), .fwd_b_sel(b_sel), .stall_count(cnt));

    data_hazard_unit #(.LOAD_USE_STALLS(2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .of_ir(of_ir), .of_valid(of_valid),
        .freeze(freeze), .flush(flush), .stall(stall2),
        .fwd_a_sel(a_sel2), .fwd_b_sel(b_sel2), .stall_count(cnt2));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_r(input logic [4:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'd0};
    endfunction

    function automatic logic [31:0] alu_i(input logic [4:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [17:0] imm);
        return {op, 1'b1, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] ld_i(input logic [3:0] rd, input logic [3:0] rs1,
                                         input logic [17:0] imm);
        return {5'b01110, 1'b1, rd, rs1, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_of(input logic [31:0] ir, input logic v);
        of_ir    = ir;
        of_valid = v;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; of_valid = 1'b0; of_ir = '0; freeze = 1'b0; flush = 1'b0;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; freeze = 1'b0; flush = 1'b0;
        set_of(32'd0, 1'b0);
        n_vec++; if (o1 !== 5'b0) begin n_miss++; $display("FAIL reset_outputs: got %b want %b", o1, 5'b0); end
        n_vec++; if (cnt !== 4'd0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", cnt); end
        n_vec++; if (cnt2 !== 16'd0) begin n_miss++; $display("FAIL reset_count2: got %0d want 0", cnt2); end
        set_of(alu_r(c_ADD, 4'd1, 4'd1, 4'd1), 1'b1);
        n_vec++; if (o2 !== 5'b0) begin n_miss++; $display("FAIL reset_valid_of: got %b want %b", o2, 5'b0); end
        reset = 1'b0;
    endtask

    task automatic test_alu_fwd;
        do_reset;
        set_of(alu_r(c_ADD, 4'd1, 4'd2, 4'd3), 1'b1);
        n_vec++; if (o1 !== 5'b0) begin n_miss++; $display("FAIL alu_empty: got %b want %b", o1, 5'b0); end
        tick;
        set_of(alu_r(c_SUB, 4'd4, 4'd1, 4'd5), 1'b1);
        e = c_FWD ? 5'b0_01_00 : 5'b1_00_00;
        n_vec++; if (o1 !== e) begin n_miss++; $display("FAIL alu_ex_fwd: got %b want %b", o1, e); end
        n_vec++; if (o2 !== e) begin n_miss++; $display("FAIL alu_ex_fwd2: got %b want %b", o2, e); end
        tick;
        set_of(alu_r(c_ADD, 4'd6, 4'd5, 4'd1), 1'b1);
        e = c_FWD ? 5'b0_00_10 : 5'b1_00_00;
        n_vec++; if (o1 !== e) begin n_miss++; $display("FAIL alu_ma_fwd_b: got %b want %b", o1, e); end
    endtask

    task automatic test_rw_fwd;
        do_reset;
        set_of(alu_r(c_ADD, 4'd1, 4'd2, 4'd3), 1'b1);
        tick;
        set_of(32'd0, 1'b0);
        tick;
        tick;
        set_of(alu_r(c_ADD, 4'd7, 4'd1, 4'd1), 1'b1);
        e = c_FWD ? 5'b0_11_11 : 5'b1_00_00;
        n_vec++; if (o1 !== e) begin n_miss++; $display("FAIL rw_same_src: got %b want %b", o1, e); end
        tick;
        n_vec++; if (cnt !== (c_FWD ? 4'd0 : 4'd1)) begin n_miss++; $display("FAIL rw_count: got %0d want %0d", cnt, c_FWD ? 0 : 1); end
    endtask

    task automatic test_same_dest;
        do_reset;
        set_of(alu_r(c_ADD, 4'd1, 4'd2, 4'd3), 1'b1);
        tick;
        set_of(alu_r(c_ADD, 4'd1, 4'd4, 4'd5), 1'b1);
        n_vec++; if (o1 !== 5'b0) begin n_miss++; $display("FAIL same_dest_indep: got %b want %b", o1, 5'b0); end
        tick;
        set_of(alu_r(c_SUB, 4'd6, 4'd1, 4'd8), 1'b1);
        e = c_FWD ? 5'b0_01_00 : 5'b1_00_00;
        n_vec++; if (o1 !== e) begin n_miss++; $display("FAIL same_dest_youngest: got %b want %b", o1, e); end
    endtask

    task automatic test_load_use;
        do_reset;
        set_of(ld_i(4'd1, 4'd2, 18'd4), 1'b1);
        tick;
        set_of(alu_r(c_ADD, 4'd3, 4'd1, 4'd1), 1'b1);
        n_vec++; if (o1 !== 5'b1_00_00) begin n_miss++; $display("FAIL ld_use_c1: got %b want %b", o1, 5'b1_00_00); end
        n_vec++; if (o2 !== 5'b1_00_00) begin n_miss++; $display("FAIL ld_use_c1_lus2: got %b want %b", o2, 5'b1_00_00); end
        tick;
        e = c_FWD ? 5'b0_10_10 : 5'b1_00_00;
        n_vec++; if (o1 !== e) begin n_miss++; $display("FAIL ld_use_c2: got %b want %b", o1, e); end
        n_vec++; if (o2 !== 5'b1_00_00) begin n_miss++; $display("FAIL ld_use_c2_lus2: got %b want %b", o2, 5'b1_00_00); end
        tick;
        e = c_FWD ? 5'b0_11_11 : 5'b1_00_00;
        n_vec++; if (o1 !== e) begin n_miss++; $display("FAIL ld_use_c3: got %b want %b", o1, e); end
        n_vec++; if (o2 !== e) begin n_miss++; $display("FAIL ld_use_c3_lus2: got %b want %b", o2, e); end
        n_vec++; if (cnt !== (c_FWD ? 4'd1 : 4'd2)) begin n_miss++; $display("FAIL ld_use_count: got %0d want %0d", cnt, c_FWD ? 1 : 2); end
        n_vec++; if (cnt2 !== 16'd2) begin n_miss++; $display("FAIL ld_use_count2: got %0d want 2", cnt2); end
    endtask

    task automatic test_call_ret;
        do_reset;
        set_of(c_CALL, 1'b1);
        tick;
        set_of(c_RET, 1'b1);
        e = c_FWD ? 5'b0_01_00 : 5'b1_00_00;
        n_vec++; if (o1 !== e) begin n_miss++; $display("FAIL call_ret: got %b want %b", o1, e); end
        do_reset;
        set_of(alu_r(c_ADD, 4'd15, 4'd2, 4'd3), 1'b1);
        tick;
        set_of(alu_i(c_ADD, 4'd1, 4'd2, 18'd5), 1'b1);
        n_vec++; if (o1 !== 5'b0) begin n_miss++; $display("FAIL imm_no_src2: got %b want %b", o1, 5'b0); end
    endtask

    task automatic test_flush;
        do_reset;
        set_of(ld_i(4'd1, 4'd2, 18'd4), 1'b1);
        tick;
        flush = 1'b1;
        set_of(alu_r(c_ADD, 4'd3, 4'd1, 4'd1), 1'b1);
        n_vec++; if (o1 !== 5'b0) begin n_miss++; $display("FAIL flush_stall: got %b want %b", o1, 5'b0); end
        n_vec++; if (o2 !== 5'b0) begin n_miss++; $display("FAIL flush_stall2: got %b want %b", o2, 5'b0); end
        tick;
        flush = 1'b0;
        set_of(alu_r(c_ADD, 4'd9, 4'd3, 4'd8), 1'b1);
        n_vec++; if (o1 !== 5'b0) begin n_miss++; $display("FAIL flush_bubble: got %b want %b", o1, 5'b0); end
        n_vec++; if (cnt !== 4'd0) begin n_miss++; $display("FAIL flush_count: got %0d want 0", cnt); end
    endtask

    task automatic test_freeze;
        do_reset;
        set_of(ld_i(4'd1, 4'd2, 18'd4), 1'b1);
        tick;
        freeze = 1'b1;
        set_of(alu_r(c_ADD, 4'd3, 4'd1, 4'd1), 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (o1 !== 5'b1_00_00) begin n_miss++; $display("FAIL freeze_stall[%0d]: got %b want %b", i, o1, 5'b1_00_00); end
            tick;
        end
        n_vec++; if (cnt !== 4'd0) begin n_miss++; $display("FAIL freeze_count: got %0d want 0", cnt); end
        n_vec++; if (cnt2 !== 16'd0) begin n_miss++; $display("FAIL freeze_count2: got %0d want 0", cnt2); end
        freeze = 1'b0;
        #1;
        n_vec++; if (o1 !== 5'b1_00_00) begin n_miss++; $display("FAIL freeze_slots_held: got %b want %b", o1, 5'b1_00_00); end
        tick;
        n_vec++; if (cnt !== 4'd1) begin n_miss++; $display("FAIL unfreeze_count: got %0d want 1", cnt); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        set_of(ld_i(4'd1, 4'd2, 18'd4), 1'b1);
        tick;
        set_of(alu_r(c_ADD, 4'd3, 4'd1, 4'd1), 1'b1);
        tick;
        n_vec++; if (cnt !== 4'd1) begin n_miss++; $display("FAIL mid_pre_count: got %0d want 1", cnt); end
        reset = 1'b1;
        #1;
        n_vec++; if (o2 !== 5'b0) begin n_miss++; $display("FAIL mid_reset_stall: got %b want %b", o2, 5'b0); end
        n_vec++; if (cnt !== 4'd0) begin n_miss++; $display("FAIL mid_reset_count: got %0d want 0", cnt); end
        n_vec++; if (cnt2 !== 16'd0) begin n_miss++; $display("FAIL mid_reset_count2: got %0d want 0", cnt2); end
        reset = 1'b0;
        #1;
        n_vec++; if (o1 !== 5'b0) begin n_miss++; $display("FAIL mid_reset_slots: got %b want %b", o1, 5'b0); end
    endtask

    task automatic test_saturate;
        do_reset;
        set_of(ld_i(4'd1, 4'd1, 18'd0), 1'b1);
        repeat (60) tick;
        n_vec++; if (cnt !== 4'd15) begin n_miss++; $display("FAIL sat_count: got %0d want 15", cnt); end
        n_vec++; if (cnt2 !== (c_FWD ? 16'd40 : 16'd45)) begin n_miss++; $display("FAIL chain_count2: got %0d want %0d", cnt2, c_FWD ? 40 : 45); end
    endtask

    initial begin
        test_reset;
        test_alu_fwd;
        test_rw_fwd;
        test_same_dest;
        test_load_use;
        test_call_ret;
        test_flush;
        test_freeze;
        test_reset_mid;
        test_saturate;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
